// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared state encodings and defaults for decoder_rr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Default maximum number of consecutive cycles a grant may be held
    localparam int unsigned c_MAX_HOLD_DEFAULT = 8;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/decoder_2to4_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2to4_rtl
//  Description : 2-to-4 one-hot decoder; {a,b} selects the asserted output bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_2to4_rtl (
    input  logic       a,
    input  logic       b,
    output logic [3:0] y
);

    // One-hot decode of the 2-bit index {a,b}
    always_comb begin
        y           = 4'b0000;
        y[{a, b}]   = 1'b1;
    end

endmodule : decoder_2to4_rtl
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_rr_arbiter
//  Description : 4-requester round-robin arbiter with done-based release,
//                hold-time limit (forced release with timeout pulse) and a
//                mandatory idle cycle between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = c_MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    // Last counter value allowed in GRANT; reaching it forces a release
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t  r_state;
    logic [1:0]  r_gnt_id;
    logic [1:0]  r_last_id;
    logic [7:0]  r_hold_cnt;
    logic        r_timeout;

    logic [1:0]  w_pick_id;
    logic        w_pick_valid;
    logic        w_req_own;
    logic        w_hit_max;
    logic        w_exit;
    logic [3:0]  w_dec;

    // Circular priority search starting just after the most recent owner.
    // Iterating from lowest to highest priority lets the highest one win.
    always_comb begin
        logic [1:0] w_idx;
        w_idx        = 2'd0;
        w_pick_id    = r_last_id;
        w_pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last_id + 2'(k);
            if (req[w_idx]) begin
                w_pick_id    = w_idx;
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_req_own = req[r_gnt_id];
    assign w_hit_max = (r_hold_cnt == c_HOLD_LAST);
    assign w_exit    = done | ~w_req_own | w_hit_max;

    // Arbitration FSM, owner tracking, hold counter and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt_id   <= 2'd0;
            r_last_id  <= 2'd3;
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= GRANT;
                        r_gnt_id   <= w_pick_id;
                        r_last_id  <= w_pick_id;
                        r_hold_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (w_exit) begin
                        r_state   <= IDLE;
                        // Only a pure hold-limit release counts as a timeout
                        r_timeout <= w_hit_max & ~done & w_req_own;
                    end else if (r_hold_cnt != c_HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    decoder_2to4_rtl u_dec (
        .a (r_gnt_id[1]),
        .b (r_gnt_id[0]),
        .y (w_dec)
    );

    assign busy    = (r_state == GRANT);
    assign gnt     = w_dec & {4{busy}};
    assign gnt_id  = r_gnt_id;
    assign timeout = r_timeout;

endmodule : decoder_rr_arbiter
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_rr_arbiter
//  Description : Scoreboard bench for decoder_rr_arbiter. Stimulus pushes the
//                expected grant episodes; a monitor closes each episode when
//                gnt returns to zero and compares it with the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // One expected grant episode; -1 in len/gap means "not checked"
    typedef struct {
        int id;
        int len;
        int to;
        int gap;
    } exp_t;

    exp_t sb[$];

    decoder_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input int len, input int to, input int gap);
        exp_t e;
        e.id = id; e.len = len; e.to = to; e.gap = gap;
        return e;
    endfunction

    // Wait (on negedges, bounded) until grant activity matches 'want'
    task automatic wait_gnt(input bit want);
        int n;
        n = 0;
        while (((gnt != 4'b0) != want) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL wait_gnt: got no gnt level %0d expected within 50 cycles", want);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 4'b0;
        done = 1'b0;
        #1;
        chk("rst_gnt",     gnt,     0);
        chk("rst_gnt_id",  gnt_id,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        bit   in_gnt;
        int   run_len;
        int   gap;
        int   start_gap;
        int   cur_id;
        exp_t e;
        in_gnt = 1'b0; run_len = 0; gap = 0; start_gap = 0; cur_id = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gnt != 4'b0) begin
                if (!in_gnt) begin
                    in_gnt    = 1'b1;
                    run_len   = 0;
                    start_gap = gap;
                    cur_id    = int'(gnt_id);
                    chk("gnt_onehot", gnt, 32'(4'b0001 << gnt_id));
                    chk("gnt_busy",   busy, 1);
                end
                run_len++;
            end else if (in_gnt) begin
                in_gnt = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got id %0d expected none", cur_id);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", cur_id, e.id);
                    if (e.len >= 0) chk("grant_len", run_len, e.len);
                    chk("timeout", timeout, e.to);
                    if (e.gap >= 0) chk("idle_gap", start_gap, e.gap);
                end
                gap = 1;
            end else begin
                gap++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin : stim
        rst  = 1'b1;
        req  = 4'b0;
        done = 1'b0;

        // Single requester, done release then req-drop release
        apply_reset();
        sb.push_back(mk(0, 2, 0, -1));
        sb.push_back(mk(0, 3, 0, 1));
        req = 4'b0001;
        @(negedge clk);
        chk("first_gnt",    gnt,    4'b0001);
        chk("first_gnt_id", gnt_id, 0);
        wait_gnt(1'b1);
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        chk("release_idle", gnt, 0);
        wait_gnt(1'b1);
        @(negedge clk);
        @(negedge clk); req = 4'b0;
        @(negedge clk);
        done = 1'b1;              // done while idle is ignored
        @(negedge clk); done = 1'b0;
        chk("done_in_idle", busy, 0);

        // All requesting: rotation 0,1,2,3,0
        apply_reset();
        sb.push_back(mk(0, 2, 0, -1));
        sb.push_back(mk(1, 2, 0, 1));
        sb.push_back(mk(2, 2, 0, 1));
        sb.push_back(mk(3, 2, 0, 1));
        sb.push_back(mk(0, 2, 0, 1));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(1'b1);
            @(negedge clk);
            done = 1'b1;
            if (k == 4) req = 4'b0;
            @(negedge clk);
            done = 1'b0;
        end

        // Hold limit twice on requester 2, then rotation after forced release
        apply_reset();
        sb.push_back(mk(2, 8, 1, -1));
        sb.push_back(mk(2, 8, 1, 1));
        sb.push_back(mk(1, 2, 0, 1));
        req = 4'b0100;
        wait_gnt(1'b1);
        wait_gnt(1'b0);
        wait_gnt(1'b1);
        repeat (4) @(negedge clk);
        req = 4'b0110;
        wait_gnt(1'b0);
        wait_gnt(1'b1);
        @(negedge clk); done = 1'b1; req = 4'b0;
        @(negedge clk); done = 1'b0;

        // done coincides with the hold limit: no timeout
        apply_reset();
        sb.push_back(mk(3, 8, 0, -1));
        req = 4'b1000;
        wait_gnt(1'b1);
        repeat (7) @(negedge clk);
        done = 1'b1;
        @(negedge clk); done = 1'b0; req = 4'b0;
        chk("coincide_idle", gnt, 0);

        // Asynchronous reset mid-grant, then restart from requester 0
        sb.push_back(mk(3, 2, 0, -1));
        sb.push_back(mk(0, 2, 0, -1));
        @(negedge clk); req = 4'b1000;
        wait_gnt(1'b1);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1001;
        #1;
        chk("async_rst_gnt",  gnt,  0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        wait_gnt(1'b1);
        chk("post_rst_gnt", gnt, 4'b0001);
        @(negedge clk); done = 1'b1; req = 4'b0;
        @(negedge clk); done = 1'b0;

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decoder_rr_arbiter
`default_nettype wire

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant is held (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: request from requester i on bit i, level-sensitive.
REQ-005 The block SHALL have port done, input, 1 bit: single-cycle pulse from the current owner releasing the grant.
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-007 The block SHALL have port gnt_id, output, 2 bits: binary index of the current or most recent owner, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in state GRANT.
REQ-009 The block SHALL have port timeout, output, 1 bit: single-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The state machine SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req != 0, the block SHALL pick the first set req bit searching circularly from (last_id+1) mod 4, then last_id+2, last_id+3, and last_id itself.
REQ-012 The chosen index SHALL load gnt_id and last_id, and the FSM SHALL enter GRANT at the same edge, so gnt appears one cycle after req is first sampled.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE, hold gnt = 0, and leave gnt_id and last_id unchanged.
REQ-014 gnt SHALL equal the 2-to-4 decode of gnt_id while busy is high, and SHALL be 4'b0000 otherwise.
REQ-015 A hold counter SHALL clear on entry to GRANT and increment by 1 each cycle in GRANT, saturating at MAX_HOLD-1.
REQ-016 GRANT SHALL exit to IDLE at the next edge when done = 1, when req[gnt_id] = 0, or when the hold counter = MAX_HOLD-1.
REQ-017 When several exit conditions occur together, the block SHALL exit once; timeout SHALL pulse only if done = 0 and req[gnt_id] = 1.
REQ-018 Every release SHALL pass through exactly one IDLE cycle with gnt = 0, giving no back-to-back grants.
REQ-019 A done pulse received in IDLE SHALL be ignored.
REQ-020 Changes to req bits other than gnt_id during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-021 After a forced release, the released requester SHALL have the lowest priority in the next arbitration.

Reset
REQ-022 On rst high, the block SHALL immediately force state IDLE, gnt = 0, gnt_id = 0, last_id = 3 (so requester 0 has first priority), hold counter = 0, busy = 0 and timeout = 0.
REQ-023 Reset asserted during GRANT SHALL drop gnt asynchronously; arbitration SHALL restart at the first clk edge after rst deasserts.

Structure
REQ-024 State encodings (IDLE = 1'b0, GRANT = 1'b1) and the default MAX_HOLD SHALL live in a shared package, arb_pkg.
REQ-025 The one-hot grant SHALL be produced by one instance of decoder_2to4_rtl, with a = gnt_id[1], b = gnt_id[0], and its output ANDed with busy.
REQ-026 The round-robin pick SHALL be combinational inside decoder_rr_arbiter; no other sub-module SHALL be used.

Verification
REQ-027 Reset, then req = 4'b0001 held: gnt = 0001 and gnt_id = 0 one cycle later; done pulse -> gnt = 0000 for one cycle, then gnt = 0001 again.
REQ-028 req = 4'b1111 with done pulsed on the second GRANT cycle of each grant: grant order 0, 1, 2, 3, 0, each separated by one idle cycle.
REQ-029 req = 4'b0100 held, no done, MAX_HOLD = 8: gnt = 0100 for exactly 8 cycles, timeout pulses once, gnt = 0000 for one cycle, then gnt = 0100 again.
REQ-030 req = 4'b0110 at the moment of a forced release of owner 2: the next grant goes to 1, not 2.
REQ-031 rst asserted mid-GRANT with gnt = 1000: gnt = 0000 with no clk edge required; after release with req = 1001, the first grant is 0001.
REQ-032 done and timeout conditions coincide on the same cycle: a single release occurs and timeout stays 0.
